// File: rtl/usb_sched_pkg.sv
// rtl/usb_sched_pkg.sv - shared encodings and width helpers for the USB burst scheduler
package usb_sched_pkg;

    // One-hot scheduler states
    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_QUAL  = 5'b00010;
    localparam logic [4:0] ST_START = 5'b00100;
    localparam logic [4:0] ST_BURST = 5'b01000;
    localparam logic [4:0] ST_GAP   = 5'b10000;

    // Burst direction as seen on burst_dir_out
    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

    // Bits needed to index n items (at least one bit)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold the values 0..max_count
    function automatic int cnt_w(input int max_count);
        return (max_count > 0) ? $clog2(max_count + 1) : 1;
    endfunction

endpackage

// File: rtl/usb_burst_scheduler_rr_arbiter.sv
// rtl/usb_burst_scheduler_rr_arbiter.sv - rotating-priority pick of one ready TX channel
module rr_arbiter
    import usb_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [CH_W-1:0]   idx_o,
    output logic              any_o
);

    logic [CH_W-1:0] pos;
    logic            found;

    // Scan upward from ptr_i; NUM_CH is a power of two so the index addition wraps on its own
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = |req_i;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pos = ptr_i + CH_W'(k);
            if (!found && req_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
    end

endmodule

// File: rtl/usb_burst_scheduler.sv
// rtl/usb_burst_scheduler.sv - picks RX/TX direction and TX channel for each USB FIFO burst
module usb_burst_scheduler
    import usb_sched_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int DEBOUNCE      = 3,
    parameter int GAP_CYCLES    = 2,
    parameter int BURST_TIMEOUT = 2048,
    localparam int CH_W = idx_w(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              usb_rxf_n_in,
    input  logic              usb_txe_n_in,
    input  logic              rx_prog_full_in,
    input  logic [NUM_CH-1:0] tx_ready_in,
    input  logic              burst_done_in,
    output logic              burst_start_out,
    output logic              burst_dir_out,
    output logic [NUM_CH-1:0] tx_grant_out,
    output logic [CH_W-1:0]   tx_sel_out,
    output logic              busy_out,
    output logic              timeout_err_out
);

    localparam int DEB_W = cnt_w(DEBOUNCE);
    localparam int TO_W  = cnt_w(BURST_TIMEOUT);
    localparam int GAP_W = cnt_w(GAP_CYCLES);

    logic [4:0]        state_q, state_d;
    logic              dir_q, dir_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic              last_dir_q, last_dir_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DEB_W-1:0]  deb_ctr_q, deb_ctr_d;
    logic [TO_W-1:0]   to_ctr_q, to_ctr_d;
    logic [GAP_W-1:0]  gap_ctr_q, gap_ctr_d;
    logic              err_q, err_d;

    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              dir_out_q, dir_out_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [CH_W-1:0]   sel_out_q, sel_out_d;

    logic [NUM_CH-1:0] arb_grant;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_any;
    logic              rx_req, tx_req, qual_ok;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i   (tx_ready_in),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign rx_req = !usb_rxf_n_in && !rx_prog_full_in;
    assign tx_req = !usb_txe_n_in && arb_any;

    // Only the request that was latched in IDLE keeps the debounce running
    assign qual_ok = (dir_q == DIR_RX) ? rx_req : (!usb_txe_n_in && |(tx_ready_in & gnt_q));

    // State, bookkeeping and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_RX;
            sel_q      <= '0;
            gnt_q      <= '0;
            last_dir_q <= DIR_TX;
            rr_ptr_q   <= '0;
            deb_ctr_q  <= '0;
            to_ctr_q   <= '0;
            gap_ctr_q  <= '0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            dir_out_q  <= DIR_RX;
            grant_q    <= '0;
            sel_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            last_dir_q <= last_dir_d;
            rr_ptr_q   <= rr_ptr_d;
            deb_ctr_q  <= deb_ctr_d;
            to_ctr_q   <= to_ctr_d;
            gap_ctr_q  <= gap_ctr_d;
            err_q      <= err_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            dir_out_q  <= dir_out_d;
            grant_q    <= grant_d;
            sel_out_q  <= sel_out_d;
        end
    end

    // Next-state: select in IDLE, debounce in QUAL, watch for done or timeout in BURST
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        last_dir_d = last_dir_q;
        rr_ptr_d   = rr_ptr_q;
        deb_ctr_d  = deb_ctr_q;
        to_ctr_d   = to_ctr_q;
        gap_ctr_d  = gap_ctr_q;
        err_d      = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_req || tx_req) begin
                    if (rx_req && tx_req) begin
                        dir_d = ~last_dir_q;
                    end else begin
                        dir_d = tx_req ? DIR_TX : DIR_RX;
                    end
                    sel_d     = arb_idx;
                    gnt_d     = arb_grant;
                    deb_ctr_d = '0;
                    state_d   = ST_QUAL;
                end
            end
            ST_QUAL: begin
                if (!qual_ok) begin
                    state_d = ST_IDLE;
                end else if (deb_ctr_q == DEB_W'(DEBOUNCE - 1)) begin
                    state_d = ST_START;
                end else begin
                    deb_ctr_d = deb_ctr_q + DEB_W'(1);
                end
            end
            ST_START: begin
                to_ctr_d = '0;
                state_d  = ST_BURST;
            end
            ST_BURST: begin
                // Done wins over a simultaneous timeout expiry
                if (burst_done_in) begin
                    last_dir_d = dir_q;
                    if (dir_q == DIR_TX) begin
                        rr_ptr_d = sel_q + CH_W'(1);
                    end
                    gap_ctr_d = '0;
                    state_d   = ST_GAP;
                end else if (to_ctr_q == TO_W'(BURST_TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    gap_ctr_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    to_ctr_d = to_ctr_q + TO_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_ctr_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_ctr_d = gap_ctr_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode of the next state so every output lines up with its state
    always_comb begin
        start_d   = (state_d == ST_START);
        busy_d    = (state_d != ST_IDLE);
        dir_out_d = dir_d;
        grant_d   = '0;
        sel_out_d = '0;
        if ((state_d == ST_START || state_d == ST_BURST) && dir_d == DIR_TX) begin
            grant_d   = gnt_d;
            sel_out_d = sel_d;
        end
    end

    assign burst_start_out = start_q;
    assign burst_dir_out   = dir_out_q;
    assign tx_grant_out    = grant_q;
    assign tx_sel_out      = sel_out_q;
    assign busy_out        = busy_q;
    assign timeout_err_out = err_q;

endmodule
